mem_responder_4b: RTL and testbench

// - Responder end of the 4B memory request/response protocol: accepts mem_req_4B_t on a val/rdy port,

---
 rtl/mem_msg_pkg.sv | 36 +++
 rtl/mem_resp_fifo.sv | 54 +++++
 rtl/mem_responder_4b.sv | 104 ++++++++++
 tb/tb_mem_responder_4b.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_msg_pkg.sv
// Shared 4B memory request/response message types and byte-lane helper.
package mem_msg_pkg;

  localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_READ  = 3'd0;
  localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // len=0 means a full word; lanes shifted past byte 3 fall off the top.
  function automatic logic [3:0] byte_lanes(input logic [1:0] len, input logic [1:0] off);
    logic [7:0] m;
    case (len)
      2'd0:    m = 8'b0000_1111;
      2'd1:    m = 8'b0000_0001;
      2'd2:    m = 8'b0000_0011;
      default: m = 8'b0000_0111;
    endcase
    m = m << off;
    return m[3:0];
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Generic synchronous FIFO, DEPTH entries of type T.
// Latency: enq visible at deq_dat the cycle after the enq edge. Backpressure: enq ignored when full.
module mem_resp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enq,
  input  T     enq_dat,
  input  logic deq,
  output T     deq_dat,
  output logic full,
  output logic empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 store [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_enq, do_deq;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_enq  = enq && !full;
  assign do_deq  = deq && !empty;
  assign deq_dat = store[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_enq) wr_ptr <= ptr_inc(wr_ptr);
      if (do_deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) store[wr_ptr] <= enq_dat;
  end

endmodule

// File: rtl/mem_responder_4b.sv
// 4B memory responder: services requests against a word array and returns responses in order.
// Latency: LATENCY cycles accept-to-resp_val. Backpressure: memreq_rdy drops at MAX_OUTST outstanding.
module mem_responder_4b
  import mem_msg_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  input  mem_req_4B_t  memreq_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy,
  output mem_resp_4B_t memresp_msg
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic               run_q;
  logic [CNT_W-1:0]   outst_cnt;
  logic               req_fire, resp_fire;
  logic [31:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]  idx;
  logic [1:0]         off;
  logic [4:0]         sh;
  logic [3:0]         lanes;
  logic [31:0]        lane_mask, rd_word, wr_shift;
  logic               is_read, is_write;
  mem_resp_4B_t       resp_new;
  logic [LATENCY-1:0] pipe_vld;
  mem_resp_4B_t       pipe_dat [LATENCY];
  mem_resp_4B_t       fifo_head;
  logic               fifo_full, fifo_empty;
  logic               unused_ok;

  // run_q keeps ready low during reset and for the first edge after release
  assign memreq_rdy  = run_q && (outst_cnt < CNT_W'(MAX_OUTST));
  assign req_fire    = memreq_val && memreq_rdy;
  assign resp_fire   = memresp_val && memresp_rdy;
  assign memresp_val = !fifo_empty;
  assign memresp_msg = fifo_empty ? '0 : fifo_head;

  assign idx       = memreq_msg.addr[ADDR_W+1:2];
  assign off       = memreq_msg.addr[1:0];
  assign sh        = {off, 3'b000};
  assign lanes     = byte_lanes(memreq_msg.len, off);
  assign lane_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  assign rd_word   = mem[idx];
  assign wr_shift  = memreq_msg.data << sh;
  assign is_read   = (memreq_msg.type_ == VC_MEM_REQ_MSG_TYPE_READ);
  assign is_write  = (memreq_msg.type_ == VC_MEM_REQ_MSG_TYPE_WRITE);
  assign unused_ok = ^{memreq_msg.addr[31:ADDR_W+2], fifo_full};

  always_comb begin
    resp_new        = '0;
    resp_new.type_  = memreq_msg.type_;
    resp_new.opaque = memreq_msg.opaque;
    resp_new.len    = memreq_msg.len;
    if (is_read) resp_new.data = (rd_word & lane_mask) >> sh;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req_fire && is_write && lanes[i]) mem[idx][8*i +: 8] <= wr_shift[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q     <= 1'b0;
      outst_cnt <= '0;
      pipe_vld  <= '0;
    end else begin
      run_q       <= 1'b1;
      pipe_vld[0] <= req_fire;
      for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      case ({req_fire, resp_fire})
        2'b10:   outst_cnt <= outst_cnt + CNT_W'(1);
        2'b01:   outst_cnt <= outst_cnt - CNT_W'(1);
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pipe_dat[0] <= resp_new;
    for (int i = 1; i < LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  // Never stalls: outst_cnt bounds pipe+FIFO occupancy to the FIFO depth
  mem_resp_fifo #(.DEPTH(MAX_OUTST), .T(mem_resp_4B_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .enq     (pipe_vld[LATENCY-1]),
    .enq_dat (pipe_dat[LATENCY-1]),
    .deq     (resp_fire),
    .deq_dat (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_mem_responder_4b.sv
// Scoreboard bench for mem_responder_4b: driver pushes expected responses, monitor pops on fire.
module tb_mem_responder_4b;
  import mem_msg_pkg::*;

  localparam int LAT = 2;
  localparam logic [2:0] RD = VC_MEM_REQ_MSG_TYPE_READ;
  localparam logic [2:0] WR = VC_MEM_REQ_MSG_TYPE_WRITE;

  typedef struct {
    mem_resp_4B_t msg;
    int           exp_cyc;
    bit           chk_lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  mem_req_4B_t  memreq_msg;
  mem_resp_4B_t memresp_msg;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   lat_chk = 1'b0;
  exp_t sbq [$];
  mem_resp_4B_t held;
  bit   held_vld = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_4b #(.ADDR_W(10), .LATENCY(LAT), .MAX_OUTST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic mem_resp_4B_t mk(input logic [2:0] t, input logic [7:0] op,
                                      input logic [1:0] l, input logic [31:0] d);
    mem_resp_4B_t r;
    r.type_ = t; r.opaque = op; r.test = 2'd0; r.len = l; r.data = d;
    return r;
  endfunction

  // Drives at negedge; accept happens on the following posedge once rdy is seen.
  task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                      input logic [1:0] l, input logic [31:0] d, input logic [31:0] exp_d);
    int w = 0;
    exp_t e;
    @(negedge clk);
    memreq_val = 1'b1;
    memreq_msg = '{t, op, a, l, d};
    while (!memreq_rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!memreq_rdy) begin
      n_tests++; n_fail++;
      $display("FAIL req_timeout: rdy=%b required 1 op=%h", memreq_rdy, op);
      memreq_val = 1'b0;
      return;
    end
    e.msg = mk(t, op, l, exp_d);
    e.exp_cyc = cyc + 1 + LAT;
    e.chk_lat = lat_chk;
    sbq.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    memreq_val = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses still pending, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst && memresp_val) begin
      if (!memresp_rdy) begin
        if (held_vld) check("resp_hold_stable", memresp_msg, held);
        held = memresp_msg;
        held_vld = 1'b1;
      end else begin
        held_vld = 1'b0;
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_resp: got %h required none", memresp_msg);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("resp_msg", memresp_msg, e.msg);
          if (e.chk_lat) check("resp_latency", cyc, e.exp_cyc);
        end
      end
    end else begin
      held_vld = 1'b0;
    end
  end

  initial begin
    rst = 1'b0;
    memreq_val = 1'b0;
    memreq_msg = '0;
    memresp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_rdy", memreq_rdy, 0);
    check("rst_resp_val", memresp_val, 0);
    check("rst_resp_msg", memresp_msg, 0);
    rst = 1'b1;
    check("rdy_low_at_release", memreq_rdy, 0);
    @(posedge clk); #1;
    check("rdy_after_release", memreq_rdy, 1);

    // Full-word and sub-word access, aliasing, unknown type
    send(WR, 8'h01, 32'h8, 2'd0, 32'h11223344, 32'h0);
    send(RD, 8'h02, 32'h8, 2'd0, 32'h0, 32'h11223344);
    send(WR, 8'h03, 32'hA, 2'd1, 32'h000000AB, 32'h0);
    send(RD, 8'h04, 32'h8, 2'd0, 32'h0, 32'h11AB3344);
    send(RD, 8'h05, 32'hA, 2'd2, 32'h0, 32'h000011AB);
    send(RD, 8'h06, 32'hA, 2'd3, 32'h0, 32'h000011AB);
    send(RD, 8'h07, 32'h1008, 2'd0, 32'h0, 32'h11AB3344);
    send(RD, 8'h08, 32'h9, 2'd1, 32'h0, 32'h00000033);
    send(RD, 8'h09, 32'h9, 2'd0, 32'h0, 32'h0011AB33);
    send(RD, 8'h0A, 32'hB, 2'd1, 32'h0, 32'h00000011);
    send(WR, 8'h0B, 32'h24, 2'd0, 32'h0, 32'h0);
    send(WR, 8'h0C, 32'h27, 2'd2, 32'h00005566, 32'h0);
    send(RD, 8'h0D, 32'h24, 2'd0, 32'h0, 32'h66000000);
    send(3'd3, 8'h0E, 32'h8, 2'd0, 32'hFFFFFFFF, 32'h0);
    send(RD, 8'h0F, 32'h8, 2'd0, 32'h0, 32'h11AB3344);
    idle();
    drain();

    // Back-to-back reads with exact latency
    for (int i = 0; i < 8; i++) send(WR, 8'h10 + 8'(i), 32'(i * 4), 2'd0, 32'hC0DE0000 | 32'(i), 32'h0);
    idle();
    drain();
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send(RD, 8'h20 + 8'(i), 32'(i * 4), 2'd0, 32'h0, 32'hC0DE0000 | 32'(i));
    lat_chk = 1'b0;
    idle();
    drain();

    // Response backpressure fills the outstanding window
    @(posedge clk); #1 memresp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(RD, 8'h30 + 8'(i), 32'(i * 4), 2'd0, 32'h0, 32'hC0DE0000 | 32'(i));
    @(negedge clk);
    memreq_msg = '{RD, 8'h34, 32'h10, 2'd0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_req_rdy_low", memreq_rdy, 0);
    end
    memreq_val = 1'b0;
    check("bp_resp_val", memresp_val, 1);
    @(posedge clk); #1 memresp_rdy = 1'b1;
    drain();
    @(negedge clk);
    check("bp_req_rdy_back", memreq_rdy, 1);

    // Reset with reads in flight
    send(WR, 8'h40, 32'h40, 2'd0, 32'hFEEDBEEF, 32'h0);
    idle();
    drain();
    @(posedge clk); #1 memresp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(RD, 8'h41 + 8'(i), 32'h40, 2'd0, 32'h0, 32'hFEEDBEEF);
    #1;
    rst = 1'b0;
    memreq_val = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    check("midrst_resp_val", memresp_val, 0);
    check("midrst_req_rdy", memreq_rdy, 0);
    rst = 1'b1;
    memresp_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_resp_after_rst", memresp_val, 0);
    end
    send(RD, 8'h50, 32'h40, 2'd0, 32'h0, 32'hFEEDBEEF);
    idle();
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
